// File: rtl/decomp_fetch_queue.sv
// Fetch stage between the instruction decompressor and the CPU.
// Issues sequential PCs to the decompressor, tracks them through its fixed
// latency, queues returned {pc, instr} pairs and hands them to the CPU over
// valid/ready. Supports branch redirects and halts on a stop instruction.
module decomp_fetch_queue #(
    parameter int                 WIDTH       = 32,
    parameter int                 DEPTH       = 4,
    parameter int                 DEC_LATENCY = 1,
    parameter logic [WIDTH-1:0]   RESET_PC    = '0,
    parameter logic [WIDTH-1:0]   STOP_INSTR  = WIDTH'(32'h1EFF2FE1)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] PCdec,
    input  logic [WIDTH-1:0] DecompressInstr,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             cpu_valid,
    input  logic             cpu_ready,
    output logic [WIDTH-1:0] cpu_instr,
    output logic [WIDTH-1:0] cpu_pc,
    output logic             halted
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    // Fetch PC and halt state
    logic [WIDTH-1:0] pc_reg;
    logic             halted_reg;

    // In-flight request tracking, one stage per cycle of decompressor latency
    logic             pipe_valid_reg [DEC_LATENCY];
    logic [WIDTH-1:0] pipe_pc_reg    [DEC_LATENCY];

    // Output FIFO storage and control
    logic [WIDTH-1:0] fifo_instr_mem [DEPTH];
    logic [WIDTH-1:0] fifo_pc_mem    [DEPTH];
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;

    logic [31:0]      inflight_count;
    logic [31:0]      occupancy;
    logic             issue;
    logic             tail_valid;
    logic             pop;
    logic             push;
    logic             stop_hit;
    logic             flush;
    logic [WIDTH-1:0] head_instr;
    logic [WIDTH-1:0] head_pc;

    // Count requests still travelling through the decompressor
    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < DEC_LATENCY; i++) begin
            inflight_count = inflight_count + 32'(pipe_valid_reg[i]);
        end
    end

    // Credit check counts in-flight requests so a returning instruction
    // always finds a free FIFO slot; no bypass, so no overflow is possible.
    assign occupancy  = 32'(count_reg) + inflight_count;
    assign issue      = !halted_reg && !redirect && (occupancy < 32'(DEPTH));
    assign tail_valid = pipe_valid_reg[DEC_LATENCY-1];
    assign head_instr = fifo_instr_mem[rd_ptr_reg];
    assign head_pc    = fifo_pc_mem[rd_ptr_reg];
    assign cpu_valid  = (count_reg != '0);
    assign pop        = cpu_valid && cpu_ready;
    // A stop instruction only takes effect once the CPU has accepted it
    assign stop_hit   = pop && (head_instr == STOP_INSTR);
    assign flush      = redirect || stop_hit;
    assign push       = tail_valid && !flush;

    // Head storage is masked while empty so the CPU never sees stale data
    assign cpu_instr  = cpu_valid ? head_instr : '0;
    assign cpu_pc     = cpu_valid ? head_pc    : '0;
    assign PCdec      = pc_reg;
    assign halted     = halted_reg;

    // Control state: PC, in-flight valids, FIFO pointers/count, halt flag
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg     <= RESET_PC;
            halted_reg <= 1'b0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEC_LATENCY; i++) begin
                pipe_valid_reg[i] <= 1'b0;
            end
        end else begin
            if (redirect) begin
                pc_reg <= redirect_pc;
            end else if (issue) begin
                pc_reg <= pc_reg + WIDTH'(4);
            end

            for (int i = DEC_LATENCY - 1; i > 0; i--) begin
                pipe_valid_reg[i] <= flush ? 1'b0 : pipe_valid_reg[i-1];
            end
            pipe_valid_reg[0] <= issue && !flush;

            if (flush) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                end
                count_reg <= count_reg + CW'(push) - CW'(pop);
            end

            if (redirect) begin
                halted_reg <= 1'b0;
            end else if (stop_hit) begin
                halted_reg <= 1'b1;
            end
        end
    end

    // Datapath: in-flight PCs and FIFO payload need no reset
    always_ff @(posedge clk) begin
        for (int i = DEC_LATENCY - 1; i > 0; i--) begin
            pipe_pc_reg[i] <= pipe_pc_reg[i-1];
        end
        pipe_pc_reg[0] <= pc_reg;
        if (push) begin
            fifo_instr_mem[wr_ptr_reg] <= DecompressInstr;
            fifo_pc_mem[wr_ptr_reg]    <= pipe_pc_reg[DEC_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_decomp_fetch_queue.sv
// Bench for decomp_fetch_queue: streaming, backpressure, redirect, halt,
// PC wrap and mid-run reset, with a scoreboard of expected delivered PCs.
module tb_decomp_fetch_queue;

    localparam logic [31:0] STOP    = 32'h1EFF2FE1;
    localparam logic [31:0] STOP_PC = 32'h1BC;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCdec;
    logic [31:0] DecompressInstr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        cpu_valid;
    logic        cpu_ready;
    logic [31:0] cpu_instr;
    logic [31:0] cpu_pc;
    logic        halted;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          deliv_cnt = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    decomp_fetch_queue #(
        .WIDTH       (32),
        .DEPTH       (4),
        .DEC_LATENCY (1),
        .RESET_PC    (32'h0),
        .STOP_INSTR  (STOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .PCdec           (PCdec),
        .DecompressInstr (DecompressInstr),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .cpu_valid       (cpu_valid),
        .cpu_ready       (cpu_ready),
        .cpu_instr       (cpu_instr),
        .cpu_pc          (cpu_pc),
        .halted          (halted)
    );

    function automatic logic [31:0] model_instr(input logic [31:0] pc);
        return (pc == STOP_PC) ? STOP : (pc ^ 32'hA5A5A5A5);
    endfunction

    // Decompressor model with one cycle of latency
    always @(posedge clk) begin
        DecompressInstr <= model_instr(PCdec);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_stream(input logic [31:0] start, input int n);
        exp_q.delete();
        deliv_cnt = 0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(start + 32'(4 * i));
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Scoreboard: every completed handshake is compared against the queue
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (!reset && cpu_valid && cpu_ready) begin
            $display("deliver pc=%h instr=%h", cpu_pc, cpu_instr);
            deliv_cnt++;
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", cpu_pc, e);
                check("sb_instr", cpu_instr, model_instr(e));
            end
        end
    end

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        cpu_ready   = 1'b1;
        step(3);

        // Reset state
        check("rst_valid",  32'(cpu_valid), 32'd0);
        check("rst_halted", 32'(halted),    32'd0);
        check("rst_pcdec",  PCdec,          32'h0);
        check("rst_cpu_pc", cpu_pc,         32'h0);
        check("rst_instr",  cpu_instr,      32'h0);

        // Streaming
        expect_stream(32'h0, 64);
        reset = 1'b0;
        step(1);
        check("stream_lat1_valid", 32'(cpu_valid), 32'd0);
        step(1);
        check("stream_first_valid", 32'(cpu_valid), 32'd1);
        check("stream_first_pc", cpu_pc, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check("stream_valid", 32'(cpu_valid), 32'd1);
            check("stream_pc", cpu_pc, 32'(4 * k));
        end

        // Backpressure
        reset     = 1'b1;
        cpu_ready = 1'b0;
        exp_q.delete();
        step(2);
        expect_stream(32'h0, 64);
        reset = 1'b0;
        step(2);
        check("bp_first_valid", 32'(cpu_valid), 32'd1);
        step(10);
        check("bp_pcdec_stall", PCdec, 32'h10);
        check("bp_head_pc", cpu_pc, 32'h0);
        cpu_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("bp_drain_valid", 32'(cpu_valid), 32'd1);
            check("bp_drain_pc", cpu_pc, 32'(4 * k));
            step(1);
        end

        // Redirect with three entries queued
        cpu_ready = 1'b0;
        step(8);
        cpu_ready = 1'b1;
        step(1);
        check("rd_head_valid", 32'(cpu_valid), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step(1);
        redirect = 1'b0;
        expect_stream(32'h100, 64);
        check("rd_flush_valid", 32'(cpu_valid), 32'd0);
        step(1);
        check("rd_t2_valid", 32'(cpu_valid), 32'd0);
        step(1);
        check("rd_t3_valid", 32'(cpu_valid), 32'd1);
        check("rd_t3_pc", cpu_pc, 32'h100);
        step(2);

        // Halt on stop instruction at 0x1BC
        redirect    = 1'b1;
        redirect_pc = 32'h180;
        step(1);
        redirect = 1'b0;
        expect_stream(32'h180, 16);
        for (int i = 0; i < 60 && !halted; i++) begin
            step(1);
        end
        check("halt_set", 32'(halted), 32'd1);
        check("halt_valid", 32'(cpu_valid), 32'd0);
        check("halt_sb_drained", 32'(exp_q.size()), 32'd0);
        check("halt_deliv_cnt", 32'(deliv_cnt), 32'd16);
        step(6);
        check("halt_hold", 32'(halted), 32'd1);
        check("halt_hold_valid", 32'(cpu_valid), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        step(1);
        redirect = 1'b0;
        expect_stream(32'h0, 64);
        check("halt_clear", 32'(halted), 32'd0);
        step(2);
        check("halt_restart_valid", 32'(cpu_valid), 32'd1);
        check("halt_restart_pc", cpu_pc, 32'h0);
        step(2);

        // PC wrap
        redirect    = 1'b1;
        redirect_pc = 32'hFFFFFFF8;
        step(1);
        redirect = 1'b0;
        expect_stream(32'hFFFFFFF8, 64);
        step(2);
        check("wrap_pc0", cpu_pc, 32'hFFFFFFF8);
        step(1);
        check("wrap_pc1", cpu_pc, 32'hFFFFFFFC);
        step(1);
        check("wrap_pc2", cpu_pc, 32'h00000000);
        check("wrap_valid", 32'(cpu_valid), 32'd1);

        // Mid-run reset with FIFO full
        cpu_ready = 1'b0;
        step(8);
        check("mr_full_valid", 32'(cpu_valid), 32'd1);
        reset = 1'b1;
        exp_q.delete();
        step(1);
        check("mr_valid", 32'(cpu_valid), 32'd0);
        check("mr_halted", 32'(halted), 32'd0);
        check("mr_pcdec", PCdec, 32'h0);
        check("mr_cpu_pc", cpu_pc, 32'h0);
        expect_stream(32'h0, 64);
        cpu_ready = 1'b1;
        reset     = 1'b0;
        step(2);
        check("mr_restart_valid", 32'(cpu_valid), 32'd1);
        check("mr_restart_pc", cpu_pc, 32'h0);
        step(4);
        check("mr_stream_pc", cpu_pc, 32'h10);
        check("mr_deliv_cnt", 32'(deliv_cnt), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
